contador_m_prog: RTL and testbench
==================================

Name: contador_m_prog

Overview:
- Programmable-modulo binary counter: runtime modulo, up/down counting, parallel load, and wrap or saturate mode.
- Registered single-cycle wrap pulse and a wrap (turn) counter.
- Successor to the fixed-modulo counters used for timing and sampling windows in the drone project; one instance can serve several periods without resynthesis.

Parameters:
N, 13, counter width in bits
M_PADRAO, 2000, modulo loaded at reset; legal range 2..2^N-1
V, 8, width of the wrap counter voltas

Ports:
clock      in   1    system clock, all state on rising edge
zera_n     in   1    synchronous active-low reset
zera_s     in   1    synchronous clear of Q only (active-high)
conta      in   1    count enable
desce      in   1    direction: 0 = up, 1 = down
satura     in   1    mode: 0 = wrap at limits, 1 = hold at limits
carrega    in   1    parallel load of Q from D
D          in   N    load value
modulo_wr  in   1    write new modulo
modulo_in  in   N    new modulo value
Q          out  N    current count (registered)
modulo     out  N    current modulo (registered)
fim        out  1    comb: Q == modulo-1
zero       out  1    comb: Q == 0
meio       out  1    comb: Q == modulo/2 - 1 (integer division)
ciclo      out  1    registered 1-cycle pulse on each wrap
voltas     out  V    registered wrap count, modulo 2^V

Behaviour:
- Reset, when zera_n=0 at a rising edge:
  - Q=0, modulo=M_PADRAO, ciclo=0, voltas=0.
  - Overrides every other input.
- Otherwise, priority per edge, first match wins: modulo_wr (accepted), zera_s, carrega, conta.
- ciclo defaults to 0 every cycle unless set by a wrap.
- modulo_wr:
  - Accepted only if modulo_in >= 2. Then modulo <= modulo_in and Q <= 0 on the same edge.
  - voltas and ciclo are unaffected.
  - If modulo_in < 2, the write is ignored and lower-priority actions proceed normally.
- zera_s: Q <= 0. modulo and voltas are kept.
- carrega: Q <= D if D < modulo, else Q <= modulo-1 (clamped). No ciclo pulse.
- conta with desce=0:
  - Q < modulo-1: Q <= Q+1.
  - Q == modulo-1, satura=0: Q <= 0, ciclo <= 1, voltas <= voltas+1 (wraps 2^V-1 -> 0).
  - Q == modulo-1, satura=1: Q holds, no ciclo, no voltas change.
- conta with desce=1:
  - Q > 0: Q <= Q-1.
  - Q == 0, satura=0: Q <= modulo-1, ciclo <= 1, voltas <= voltas+1.
  - Q == 0, satura=1: Q holds.
- conta=0 and no other action: all registers hold.
- Latency:
  - Q, modulo, ciclo and voltas update at the edge that samples the inputs.
  - fim, zero and meio follow Q combinationally, so they are valid in the cycle after the edge.
- Invariant: Q < modulo at all times after reset. Modulo arithmetic uses N-bit compares; modulo-1 never underflows because modulo >= 2.
- Changing desce or satura mid-count takes effect at the next edge; no state is cleared.
- zera_n asserted mid-count returns all outputs to their reset values at that edge; any pending ciclo is lost.

Decomposition:
- No shared package needed.
- Local constants only: the M_PADRAO legality check (simulation-time assertion 2 <= M_PADRAO < 2^N).
- One sub-module is natural: contador_voltas (V-bit enabled incrementer with synchronous active-low reset), driven by the wrap condition. Everything else is a single always block plus comb compares.

Test Plan:
- Reset/default: zera_n=0 for 2 cycles, then conta=1 up for 1999 cycles -> Q=1999, fim=1; next edge Q=0, ciclo=1 for exactly one cycle, voltas=1; meio=1 when Q=999.
- Runtime modulo: write modulo_in=5 while Q=1234 -> Q=0, modulo=5; count up 12 cycles -> Q sequence 0..4,0..4,0,1, ciclo pulses twice, voltas=+2. modulo_in=1 with conta=1 -> write ignored, Q increments.
- Down/saturate:
  - modulo=5, desce=1, satura=0 from Q=0 -> Q=4, ciclo=1.
  - satura=1, desce=1 at Q=0 -> Q holds at 0, ciclo=0, voltas unchanged.
  - satura=1, desce=0 at Q=4 -> Q holds at 4.
- Load and priority:
  - modulo=10, carrega=1, D=7 -> Q=7; D=15 -> Q=9.
  - carrega=1 with zera_s=1 -> Q=0.
  - modulo_wr=1 (modulo_in=6) with carrega=1, D=3 -> Q=0, modulo=6.
- voltas wrap and reset mid-operation:
  - V=8, modulo=2: 512 up-counts -> voltas returns to 0.
  - zera_n=0 at Q=1, voltas=37 -> Q=0, voltas=0, modulo=M_PADRAO next cycle.

Source files
------------

// File: rtl/contador_voltas.sv
// Wrap (turn) counter: V-bit incrementer that advances once per counter wrap
// and rolls over from 2^V-1 back to 0.
module contador_voltas #(
  parameter int V = 8
) (
  input  logic         clock,
  input  logic         zera_n,
  input  logic         incrementa,
  output logic [V-1:0] voltas
);

  // Synchronous active-low clear, otherwise count each enabled cycle.
  always_ff @(posedge clock) begin
    if (!zera_n) begin
      voltas <= '0;
    end else if (incrementa) begin
      voltas <= voltas + V'(1);
    end
  end

endmodule

// File: rtl/contador_m_prog.sv
// Programmable-modulo counter: runtime modulo, up/down, parallel load with
// clamping, wrap or saturate at the limits, registered wrap pulse and a
// wrap counter.
module contador_m_prog #(
  parameter int N        = 13,
  parameter int M_PADRAO = 2000,
  parameter int V        = 8
) (
  input  logic         clock,
  input  logic         zera_n,
  input  logic         zera_s,
  input  logic         conta,
  input  logic         desce,
  input  logic         satura,
  input  logic         carrega,
  input  logic [N-1:0] D,
  input  logic         modulo_wr,
  input  logic [N-1:0] modulo_in,
  output logic [N-1:0] Q,
  output logic [N-1:0] modulo,
  output logic         fim,
  output logic         zero,
  output logic         meio,
  output logic         ciclo,
  output logic [V-1:0] voltas
);

  localparam logic [N-1:0] MOD_RESET = N'(M_PADRAO);

  logic [N-1:0] limite;
  logic         wr_ok;
  logic         no_limite;
  logic         passo;
  logic         volta;

  // modulo is always >= 2, so limite never underflows.
  assign limite    = modulo - N'(1);
  assign wr_ok     = modulo_wr && (modulo_in >= N'(2));
  assign no_limite = desce ? (Q == '0) : (Q == limite);
  assign passo     = !wr_ok && !zera_s && !carrega && conta;
  // A wrap only happens on a counting step that hits the limit in wrap mode.
  assign volta     = passo && no_limite && !satura;

  assign fim  = (Q == limite);
  assign zero = (Q == '0);
  assign meio = (Q == ((modulo >> 1) - N'(1)));

  // Count/modulo register with priority: modulo write, clear, load, count.
  always_ff @(posedge clock) begin
    if (!zera_n) begin
      assert (M_PADRAO >= 2 && M_PADRAO < (1 << N))
        else $error("contador_m_prog: M_PADRAO out of range");
      Q      <= '0;
      modulo <= MOD_RESET;
      ciclo  <= 1'b0;
    end else begin
      ciclo <= volta;
      if (wr_ok) begin
        modulo <= modulo_in;
        Q      <= '0;
      end else if (zera_s) begin
        Q <= '0;
      end else if (carrega) begin
        Q <= (D < modulo) ? D : limite;
      end else if (conta) begin
        if (no_limite) begin
          if (!satura) begin
            Q <= desce ? limite : '0;
          end
        end else begin
          Q <= desce ? (Q - N'(1)) : (Q + N'(1));
        end
      end
    end
  end

  contador_voltas #(.V(V)) u_voltas (
    .clock      (clock),
    .zera_n     (zera_n),
    .incrementa (volta),
    .voltas     (voltas)
  );

endmodule

// File: tb/tb_contador_m_prog.sv
// Bench for contador_m_prog: directed scenarios with fixed expectations plus
// a randomized run compared against a behavioural model.
module tb_contador_m_prog;

  localparam int N = 13;
  localparam int V = 8;
  localparam int MP = 2000;

  logic         clock = 1'b0;
  logic         zera_n, zera_s, conta, desce, satura, carrega, modulo_wr;
  logic [N-1:0] D, modulo_in;
  logic [N-1:0] Q, modulo;
  logic         fim, zero, meio, ciclo;
  logic [V-1:0] voltas;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int mq, mmod, mv;
  bit mc;

  always #5 clock = ~clock;

  contador_m_prog #(.N(N), .M_PADRAO(MP), .V(V)) dut (
    .clock(clock), .zera_n(zera_n), .zera_s(zera_s), .conta(conta),
    .desce(desce), .satura(satura), .carrega(carrega), .D(D),
    .modulo_wr(modulo_wr), .modulo_in(modulo_in), .Q(Q), .modulo(modulo),
    .fim(fim), .zero(zero), .meio(meio), .ciclo(ciclo), .voltas(voltas)
  );

  // Apply the specification's rules to the model for the inputs now driven.
  task automatic model_step();
    mc = 0;
    if (!zera_n) begin
      mq = 0; mmod = MP; mv = 0;
    end else if (modulo_wr && int'(modulo_in) >= 2) begin
      mmod = int'(modulo_in); mq = 0;
    end else if (zera_s) begin
      mq = 0;
    end else if (carrega) begin
      mq = (int'(D) < mmod) ? int'(D) : mmod - 1;
    end else if (conta) begin
      if (!desce) begin
        if (mq + 1 < mmod) mq = mq + 1;
        else if (!satura) begin mq = 0; mc = 1; mv = (mv + 1) % (1 << V); end
      end else begin
        if (mq > 0) mq = mq - 1;
        else if (!satura) begin mq = mmod - 1; mc = 1; mv = (mv + 1) % (1 << V); end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    zera_n = 1; zera_s = 0; conta = 0; desce = 0; satura = 0;
    carrega = 0; modulo_wr = 0; D = '0; modulo_in = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    zera_n = 0; conta = 1; carrega = 1; D = 13'd55;
    tick(); tick();
    n_tests++;
    if (Q !== 13'd0 || modulo !== 13'd2000 || ciclo !== 1'b0 || voltas !== 8'd0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: Q=%0d modulo=%0d ciclo=%0b voltas=%0d zero=%0b required 0/2000/0/0/1",
               Q, modulo, ciclo, voltas, zero);
    end
  endtask

  task automatic test_count_full();
    bit meio_seen = 0;
    idle_inputs();
    conta = 1;
    for (int i = 1; i <= 1999; i++) begin
      tick();
      if (i == 999) begin
        n_tests++;
        if (Q !== 13'd999 || meio !== 1'b1) begin
          n_fail++;
          $display("FAIL meio_999: Q=%0d meio=%0b required 999/1", Q, meio);
        end
        meio_seen = 1;
      end
    end
    n_tests++;
    if (Q !== 13'd1999 || fim !== 1'b1 || ciclo !== 1'b0 || !meio_seen) begin
      n_fail++;
      $display("FAIL count_top: Q=%0d fim=%0b ciclo=%0b required 1999/1/0", Q, fim, ciclo);
    end
    tick();
    n_tests++;
    if (Q !== 13'd0 || ciclo !== 1'b1 || voltas !== 8'd1) begin
      n_fail++;
      $display("FAIL count_wrap: Q=%0d ciclo=%0b voltas=%0d required 0/1/1", Q, ciclo, voltas);
    end
    tick();
    n_tests++;
    if (Q !== 13'd1 || ciclo !== 1'b0) begin
      n_fail++;
      $display("FAIL ciclo_one_cycle: Q=%0d ciclo=%0b required 1/0", Q, ciclo);
    end
  endtask

  task automatic test_runtime_modulo();
    int pulses = 0;
    int v0;
    idle_inputs();
    carrega = 1; D = 13'd1234;
    tick();
    idle_inputs();
    modulo_wr = 1; modulo_in = 13'd5;
    tick();
    n_tests++;
    if (Q !== 13'd0 || modulo !== 13'd5) begin
      n_fail++;
      $display("FAIL modulo_write: Q=%0d modulo=%0d required 0/5", Q, modulo);
    end
    v0 = int'(voltas);
    idle_inputs();
    conta = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (ciclo) pulses++;
      n_tests++;
      if (Q !== 13'(k % 5)) begin
        n_fail++;
        $display("FAIL mod5_seq[%0d]: Q=%0d required %0d", k, Q, k % 5);
      end
    end
    n_tests++;
    if (pulses != 2 || int'(voltas) != (v0 + 2) % 256) begin
      n_fail++;
      $display("FAIL mod5_wraps: pulses=%0d voltas=%0d required 2/%0d", pulses, voltas, (v0 + 2) % 256);
    end
    modulo_wr = 1; modulo_in = 13'd1;
    tick();
    n_tests++;
    if (Q !== 13'd3 || modulo !== 13'd5) begin
      n_fail++;
      $display("FAIL modulo_ignored: Q=%0d modulo=%0d required 3/5", Q, modulo);
    end
  endtask

  task automatic test_down_saturate();
    int v0;
    idle_inputs();
    zera_s = 1;
    tick();
    idle_inputs();
    conta = 1; desce = 1;
    tick();
    n_tests++;
    if (Q !== 13'd4 || ciclo !== 1'b1) begin
      n_fail++;
      $display("FAIL down_wrap: Q=%0d ciclo=%0b required 4/1", Q, ciclo);
    end
    repeat (4) tick();
    v0 = int'(voltas);
    satura = 1;
    tick();
    n_tests++;
    if (Q !== 13'd0 || ciclo !== 1'b0 || int'(voltas) != v0) begin
      n_fail++;
      $display("FAIL down_sat: Q=%0d ciclo=%0b voltas=%0d required 0/0/%0d", Q, ciclo, voltas, v0);
    end
    conta = 0; carrega = 1; D = 13'd4;
    tick();
    carrega = 0; conta = 1; desce = 0;
    tick(); tick();
    n_tests++;
    if (Q !== 13'd4 || ciclo !== 1'b0 || fim !== 1'b1) begin
      n_fail++;
      $display("FAIL up_sat: Q=%0d ciclo=%0b fim=%0b required 4/0/1", Q, ciclo, fim);
    end
  endtask

  task automatic test_load_priority();
    idle_inputs();
    modulo_wr = 1; modulo_in = 13'd10;
    tick();
    idle_inputs();
    carrega = 1; D = 13'd7;
    tick();
    n_tests++;
    if (Q !== 13'd7) begin
      n_fail++;
      $display("FAIL load_7: Q=%0d required 7", Q);
    end
    D = 13'd15;
    tick();
    n_tests++;
    if (Q !== 13'd9) begin
      n_fail++;
      $display("FAIL load_clamp: Q=%0d required 9", Q);
    end
    zera_s = 1; conta = 1;
    tick();
    n_tests++;
    if (Q !== 13'd0 || modulo !== 13'd10) begin
      n_fail++;
      $display("FAIL clear_over_load: Q=%0d modulo=%0d required 0/10", Q, modulo);
    end
    zera_s = 0; D = 13'd3; modulo_wr = 1; modulo_in = 13'd6;
    tick();
    n_tests++;
    if (Q !== 13'd0 || modulo !== 13'd6) begin
      n_fail++;
      $display("FAIL write_over_load: Q=%0d modulo=%0d required 0/6", Q, modulo);
    end
  endtask

  task automatic test_voltas_wrap();
    idle_inputs();
    zera_n = 0;
    tick();
    idle_inputs();
    modulo_wr = 1; modulo_in = 13'd2;
    tick();
    idle_inputs();
    conta = 1;
    repeat (512) tick();
    n_tests++;
    if (voltas !== 8'd0 || Q !== 13'd0) begin
      n_fail++;
      $display("FAIL voltas_rollover: voltas=%0d Q=%0d required 0/0", voltas, Q);
    end
    repeat (75) tick();
    n_tests++;
    if (voltas !== 8'd37 || Q !== 13'd1) begin
      n_fail++;
      $display("FAIL voltas_37: voltas=%0d Q=%0d required 37/1", voltas, Q);
    end
    zera_n = 0;
    tick();
    n_tests++;
    if (Q !== 13'd0 || voltas !== 8'd0 || modulo !== 13'd2000 || ciclo !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: Q=%0d voltas=%0d modulo=%0d ciclo=%0b required 0/0/2000/0",
               Q, voltas, modulo, ciclo);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 4000; i++) begin
      zera_n    = ($urandom_range(0, 199) != 0);
      zera_s    = ($urandom_range(0, 49) == 0);
      carrega   = ($urandom_range(0, 19) == 0);
      modulo_wr = ($urandom_range(0, 29) == 0);
      conta     = ($urandom_range(0, 3) != 0);
      desce     = ($urandom_range(0, 1) == 1);
      satura    = ($urandom_range(0, 5) == 0);
      D         = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 25));
      modulo_in = ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'($urandom_range(0, 20));
      tick();
      n_tests++;
      if (Q !== 13'(mq) || modulo !== 13'(mmod) || ciclo !== mc || voltas !== 8'(mv) ||
          fim !== (mq == mmod - 1) || zero !== (mq == 0) || meio !== (mq == mmod / 2 - 1) ||
          !(Q < modulo)) begin
        n_fail++;
        $display("FAIL random[%0d]: Q=%0d mod=%0d ciclo=%0b voltas=%0d fim=%0b zero=%0b meio=%0b required %0d/%0d/%0b/%0d",
                 i, Q, modulo, ciclo, voltas, fim, zero, meio, mq, mmod, mc, mv);
      end
    end
  endtask

  initial begin
    mq = 0; mmod = MP; mv = 0; mc = 0;
    test_reset();
    test_count_full();
    test_runtime_modulo();
    test_down_saturate();
    test_load_priority();
    test_voltas_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
